sphere_discriminant_unit: RTL and testbench

Front end of the sphere-intersection path: accepts one ray/sphere pair, computes the half-quadratic terms B and C, the discriminant B² − 4C, and its integer square root. It presents RootDiscriminant, B, QuickIntersects and OldDistance to the distance-calculator stage under a valid/ready handshake. The sqrt is an iterative one-bit-per-cycle sub-unit. Ray direction is taken as unit length (A = 1), matching the downstream t = (−B ± √disc) >> 1.

---
 rtl/sphere_discriminant_unit_pkg.sv | 31 +++
 rtl/sphere_discriminant_unit_if.sv | 29 ++
 rtl/sphere_discriminant_unit_isqrt_iter.sv | 73 +++++++
 rtl/sphere_discriminant_unit.sv | 167 ++++++++++++++++
 tb/tb_sphere_discriminant_unit.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/sphere_discriminant_unit_pkg.sv
// Shared types and widths for the sphere discriminant front end.
package sphere_pkg;

  localparam int COORD_W = 16;
  localparam int L_W     = 17;
  localparam int DL_W    = 35;
  localparam int LL_W    = 36;
  localparam int BRAW_W  = DL_W + 1;
  localparam int DISC_W  = 40;
  localparam int RAD_W   = 32;
  localparam int ROOT_W  = 16;

  localparam logic signed [COORD_W-1:0] B_MAX = 16'sh7FFF;
  localparam logic signed [COORD_W-1:0] B_MIN = 16'sh8000;

  typedef enum logic [2:0] {IDLE, DOT, DISC, SQRT, HOLD} state_t;

  typedef struct packed {
    logic [COORD_W-1:0] ox, oy, oz;
    logic [COORD_W-1:0] dx, dy, dz;
    logic [COORD_W-1:0] cx, cy, cz;
    logic [COORD_W-1:0] radius;
  } req_t;

  function automatic logic signed [COORD_W-1:0] sat_b(input logic signed [BRAW_W-1:0] v);
    if (v > BRAW_W'(B_MAX)) return B_MAX;
    if (v < BRAW_W'(B_MIN)) return B_MIN;
    return v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/sphere_discriminant_unit_if.sv
// Request/response bundle between the ray scheduler, this unit and the distance calculator.
interface sphere_discriminant_unit_if;
  import sphere_pkg::*;

  logic                      InValid;
  logic                      InReady;
  logic signed [COORD_W-1:0] Ox, Oy, Oz;
  logic signed [COORD_W-1:0] Dx, Dy, Dz;
  logic signed [COORD_W-1:0] Cx, Cy, Cz;
  logic        [COORD_W-1:0] Radius;
  logic        [COORD_W-1:0] OldDistanceIn;
  logic                      OutValid;
  logic                      DownReady;
  logic        [ROOT_W-1:0]  RootDiscriminant;
  logic signed [COORD_W-1:0] B;
  logic                      QuickIntersects;
  logic        [COORD_W-1:0] OldDistance;

  modport master (
    output InValid, Ox, Oy, Oz, Dx, Dy, Dz, Cx, Cy, Cz, Radius, OldDistanceIn, DownReady,
    input  InReady, OutValid, RootDiscriminant, B, QuickIntersects, OldDistance
  );

  modport slave (
    input  InValid, Ox, Oy, Oz, Dx, Dy, Dz, Cx, Cy, Cz, Radius, OldDistanceIn, DownReady,
    output InReady, OutValid, RootDiscriminant, B, QuickIntersects, OldDistance
  );

endinterface

// File: rtl/sphere_discriminant_unit_isqrt_iter.sv
// Restoring integer square root, one root bit (two radicand bits) per cycle.
module isqrt_iter #(
  parameter int ITERS = 16
) (
  input  logic        CLK,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] radicand,
  output logic        busy,
  output logic        done,
  output logic [15:0] root
);

  localparam int CNT_W = $clog2(ITERS + 1);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rad_q, rad_d;
  logic [17:0]      rem_q, rem_d;
  logic [15:0]      root_q, root_d;
  logic [19:0]      rem_sh, trial;

  // done flags the final iteration cycle; root carries that cycle's result so the
  // caller can capture it on the same edge.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rad_d  = rad_q;
    rem_d  = rem_q;
    root_d = root_q;
    rem_sh = {rem_q, rad_q[31:30]};
    trial  = {2'b00, root_q, 2'b01};
    done   = busy_q && (cnt_q == '0);
    if (busy_q) begin
      rad_d = {rad_q[29:0], 2'b00};
      if (rem_sh >= trial) begin
        rem_d  = 18'(rem_sh - trial);
        root_d = {root_q[14:0], 1'b1};
      end else begin
        rem_d  = rem_sh[17:0];
        root_d = {root_q[14:0], 1'b0};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (done) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CNT_W'(ITERS - 1);
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!aresetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rad_q  <= rad_d;
      rem_q  <= rem_d;
      root_q <= root_d;
    end
  end

  assign busy = busy_q;
  assign root = root_d;

endmodule

// File: rtl/sphere_discriminant_unit.sv
// Ray/sphere discriminant front end: B, C, B^2-4C and floor(sqrt) for the distance stage.
// Build option SPHERE_QUICK_REJECT_EN: also reject spheres fully behind an outside origin.
//
// state | meaning
// IDLE  | ready, capture request on InValid
// DOT   | L = O - C; register D.L, L.L, R^2
// DISC  | saturate B, form discriminant, reject or launch sqrt
// SQRT  | wait for isqrt_iter to finish
// HOLD  | OutValid, outputs frozen until DownReady
module sphere_discriminant_unit
  import sphere_pkg::*;
#(
  parameter int SQRT_ITERS = 16
) (
  input logic                 CLK,
  input logic                 aresetn,
  sphere_discriminant_unit_if.slave bus
);

  state_t                    state_q, state_d;
  req_t                      req_q, req_d;
  logic signed [DL_W-1:0]    dl_q, dl_d;
  logic        [LL_W-1:0]    ll_q, ll_d;
  logic        [RAD_W-1:0]   r2_q, r2_d;
  logic        [ROOT_W-1:0]  root_q, root_d;
  logic signed [COORD_W-1:0] b_q, b_d;
  logic                      qi_q, qi_d;
  logic        [COORD_W-1:0] old_dist_q, old_dist_d;

  logic signed [L_W-1:0]     lx, ly, lz;
  logic signed [DL_W-1:0]    dl_calc;
  logic signed [LL_W-1:0]    ll_calc;
  logic        [RAD_W-1:0]   r2_calc;
  logic signed [BRAW_W-1:0]  b_raw;
  logic signed [COORD_W-1:0] b_sat;
  logic signed [DISC_W-1:0]  cterm, b_sq, disc;
  logic        [RAD_W-1:0]   disc_clamped;
  logic                      reject;

  logic                      sqrt_start, sqrt_busy, sqrt_done;
  logic        [ROOT_W-1:0]  sqrt_root;

  always_comb begin
    lx      = L_W'($signed(req_q.ox)) - L_W'($signed(req_q.cx));
    ly      = L_W'($signed(req_q.oy)) - L_W'($signed(req_q.cy));
    lz      = L_W'($signed(req_q.oz)) - L_W'($signed(req_q.cz));
    dl_calc = DL_W'($signed(req_q.dx)) * DL_W'(lx)
            + DL_W'($signed(req_q.dy)) * DL_W'(ly)
            + DL_W'($signed(req_q.dz)) * DL_W'(lz);
    ll_calc = LL_W'(lx) * LL_W'(lx) + LL_W'(ly) * LL_W'(ly) + LL_W'(lz) * LL_W'(lz);
    r2_calc = RAD_W'(req_q.radius) * RAD_W'(req_q.radius);
  end

  // The discriminant uses the saturated B so downstream t = (-B +/- root) >> 1 stays consistent.
  always_comb begin
    b_raw        = $signed({dl_q, 1'b0});
    b_sat        = sat_b(b_raw);
    cterm        = $signed({{(DISC_W - LL_W){1'b0}}, ll_q})
                 - $signed({{(DISC_W - RAD_W){1'b0}}, r2_q});
    b_sq         = DISC_W'(b_sat) * DISC_W'(b_sat);
    disc         = b_sq - (cterm <<< 2);
    disc_clamped = (|disc[DISC_W-1:RAD_W]) ? '1 : disc[RAD_W-1:0];
`ifdef SPHERE_QUICK_REJECT_EN
    reject       = disc[DISC_W-1]
                 | (!cterm[DISC_W-1] && (|cterm) && !b_sat[COORD_W-1] && (|b_sat));
`else
    reject       = disc[DISC_W-1];
`endif
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    dl_d       = dl_q;
    ll_d       = ll_q;
    r2_d       = r2_q;
    root_d     = root_q;
    b_d        = b_q;
    qi_d       = qi_q;
    old_dist_d = old_dist_q;
    sqrt_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.InValid) begin
          req_d      = '{ox: bus.Ox, oy: bus.Oy, oz: bus.Oz,
                         dx: bus.Dx, dy: bus.Dy, dz: bus.Dz,
                         cx: bus.Cx, cy: bus.Cy, cz: bus.Cz,
                         radius: bus.Radius};
          old_dist_d = bus.OldDistanceIn;
          state_d    = DOT;
        end
      end
      DOT: begin
        dl_d    = dl_calc;
        ll_d    = $unsigned(ll_calc);
        r2_d    = r2_calc;
        state_d = DISC;
      end
      DISC: begin
        b_d = b_sat;
        if (reject) begin
          qi_d    = 1'b0;
          root_d  = '0;
          state_d = HOLD;
        end else begin
          sqrt_start = 1'b1;
          state_d    = SQRT;
        end
      end
      SQRT: begin
        if (sqrt_done) begin
          root_d  = sqrt_root;
          qi_d    = 1'b1;
          state_d = HOLD;
        end else if (!sqrt_busy) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.DownReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      req_q      <= '0;
      dl_q       <= '0;
      ll_q       <= '0;
      r2_q       <= '0;
      root_q     <= '0;
      b_q        <= '0;
      qi_q       <= 1'b0;
      old_dist_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      dl_q       <= dl_d;
      ll_q       <= ll_d;
      r2_q       <= r2_d;
      root_q     <= root_d;
      b_q        <= b_d;
      qi_q       <= qi_d;
      old_dist_q <= old_dist_d;
    end
  end

  isqrt_iter #(.ITERS(SQRT_ITERS)) u_isqrt (
    .CLK      (CLK),
    .aresetn  (aresetn),
    .start    (sqrt_start),
    .radicand (disc_clamped),
    .busy     (sqrt_busy),
    .done     (sqrt_done),
    .root     (sqrt_root)
  );

  assign bus.InReady          = (state_q == IDLE);
  assign bus.OutValid         = (state_q == HOLD);
  assign bus.RootDiscriminant = root_q;
  assign bus.B                = b_q;
  assign bus.QuickIntersects  = qi_q;
  assign bus.OldDistance      = old_dist_q;

endmodule

// File: tb/tb_sphere_discriminant_unit.sv
// Directed checks of sphere_discriminant_unit: hit, miss, tangent, behind, saturation, clamp, backpressure, reset.
module tb_sphere_discriminant_unit;

  logic CLK = 1'b0;
  logic aresetn;
  int   vectors = 0;
  int   miscompares = 0;

  sphere_discriminant_unit_if bus ();

  sphere_discriminant_unit #(.SQRT_ITERS(16)) dut (
    .CLK     (CLK),
    .aresetn (aresetn),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

`ifdef SPHERE_QUICK_REJECT_EN
  localparam int          BEHIND_LAT  = 3;
  localparam logic [15:0] BEHIND_ROOT = 16'd0;
  localparam logic        BEHIND_QI   = 1'b0;
`else
  localparam int          BEHIND_LAT  = 19;
  localparam logic [15:0] BEHIND_ROOT = 16'd6;
  localparam logic        BEHIND_QI   = 1'b1;
`endif

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic signed [15:0] ox, oy, oz, dx, dy, dz, cx, cy, cz,
                           input logic [15:0] rad, od);
    bus.Ox = ox; bus.Oy = oy; bus.Oz = oz;
    bus.Dx = dx; bus.Dy = dy; bus.Dz = dz;
    bus.Cx = cx; bus.Cy = cy; bus.Cz = cz;
    bus.Radius = rad; bus.OldDistanceIn = od;
  endtask

  task automatic issue(input string tag, input logic signed [15:0] cx, cy, cz,
                       input logic [15:0] rad, od, input int exp_lat,
                       input logic [15:0] exp_b, exp_root, input logic exp_qi,
                       input logic signed [15:0] dx = 16'sd1);
    int lat;
    @(negedge CLK);
    check({tag, " in_ready"}, 16'(bus.InReady), 16'd1);
    drive_req(16'sd0, 16'sd0, 16'sd0, dx, 16'sd0, 16'sd0, cx, cy, cz, rad, od);
    bus.InValid = 1'b1;
    @(negedge CLK);
    bus.InValid = 1'b0;
    lat = 1;
    while (!bus.OutValid && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, " latency"}, 16'(lat), 16'(exp_lat));
    check({tag, " B"}, bus.B, exp_b);
    check({tag, " root"}, bus.RootDiscriminant, exp_root);
    check({tag, " qi"}, 16'(bus.QuickIntersects), 16'(exp_qi));
    check({tag, " old_dist"}, bus.OldDistance, od);
  endtask

  task automatic complete(input string tag);
    bus.DownReady = 1'b1;
    @(negedge CLK);
    bus.DownReady = 1'b0;
    check({tag, " ready_after"}, 16'(bus.InReady), 16'd1);
    check({tag, " valid_after"}, 16'(bus.OutValid), 16'd0);
  endtask

  initial begin
    aresetn   = 1'b0;
    bus.InValid   = 1'b0;
    bus.DownReady = 1'b0;
    drive_req(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'd0, 16'd0);
    repeat (3) @(negedge CLK);
    check("rst out_valid", 16'(bus.OutValid), 16'd0);
    check("rst root", bus.RootDiscriminant, 16'd0);
    check("rst B", bus.B, 16'd0);
    check("rst qi", 16'(bus.QuickIntersects), 16'd0);
    check("rst old_dist", bus.OldDistance, 16'd0);
    aresetn = 1'b1;
    check("rst in_ready", 16'(bus.InReady), 16'd1);

    // Hit: L=(-10,0,0), B=-20, C=91, disc=36
    issue("hit", 16'sd10, 16'sd0, 16'sd0, 16'd3, 16'h0100, 19, 16'hFFEC, 16'd6, 1'b1);
    complete("hit");
    // Miss: C=116, disc=-64
    issue("miss", 16'sd10, 16'sd5, 16'sd0, 16'd3, 16'h0200, 3, 16'hFFEC, 16'd0, 1'b0);
    complete("miss");
    // Tangent: C=100, disc=0
    issue("tangent", 16'sd10, 16'sd3, 16'sd0, 16'd3, 16'h0300, 19, 16'hFFEC, 16'd0, 1'b1);
    complete("tangent");
    // Behind: B=20, C=91, disc=36
    issue("behind", -16'sd10, 16'sd0, 16'sd0, 16'd3, 16'h0400, BEHIND_LAT, 16'd20, BEHIND_ROOT, BEHIND_QI);
    complete("behind");
    // B saturation both ways; disc negative either way
    issue("sat_pos", -16'sd30000, 16'sd0, 16'sd0, 16'd0, 16'h0500, 3, 16'h7FFF, 16'd0, 1'b0);
    complete("sat_pos");
    issue("sat_neg", 16'sd30000, 16'sd0, 16'sd0, 16'd0, 16'h0600, 3, 16'h8000, 16'd0, 1'b0);
    complete("sat_neg");
    // Origin at centre, R=65535: disc=4*65535^2 exceeds 32 bits and clamps to 0xFFFFFFFF
    issue("clamp", 16'sd0, 16'sd0, 16'sd0, 16'hFFFF, 16'h0700, 19, 16'd0, 16'hFFFF, 1'b1);
    complete("clamp");

    // Backpressure with an ignored request in the middle of HOLD
    issue("bp", 16'sd10, 16'sd0, 16'sd0, 16'd3, 16'h1234, 19, 16'hFFEC, 16'd6, 1'b1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        drive_req(16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd10, 16'sd5, 16'sd0, 16'd3, 16'h5555);
        bus.InValid = 1'b1;
      end
      @(negedge CLK);
      bus.InValid = 1'b0;
      check("bp out_valid", 16'(bus.OutValid), 16'd1);
      check("bp in_ready", 16'(bus.InReady), 16'd0);
      check("bp B", bus.B, 16'hFFEC);
      check("bp root", bus.RootDiscriminant, 16'd6);
      check("bp qi", 16'(bus.QuickIntersects), 16'd1);
      check("bp old_dist", bus.OldDistance, 16'h1234);
    end
    complete("bp");
    repeat (5) @(negedge CLK);
    check("bp ignored valid", 16'(bus.OutValid), 16'd0);
    check("bp ignored old_dist", bus.OldDistance, 16'h1234);

    // Reset at T+10, mid-SQRT
    drive_req(16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd0, 16'sd0, 16'sd10, 16'sd0, 16'sd0, 16'd3, 16'h0900);
    bus.InValid = 1'b1;
    @(negedge CLK);
    bus.InValid = 1'b0;
    repeat (9) @(negedge CLK);
    aresetn = 1'b0;
    @(negedge CLK);
    aresetn = 1'b1;
    check("mid_rst out_valid", 16'(bus.OutValid), 16'd0);
    check("mid_rst in_ready", 16'(bus.InReady), 16'd1);
    check("mid_rst root", bus.RootDiscriminant, 16'd0);
    check("mid_rst B", bus.B, 16'd0);
    check("mid_rst qi", 16'(bus.QuickIntersects), 16'd0);
    check("mid_rst old_dist", bus.OldDistance, 16'd0);
    issue("post_rst", 16'sd10, 16'sd0, 16'sd0, 16'd3, 16'h0A00, 19, 16'hFFEC, 16'd6, 1'b1);
    complete("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
